// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, debounce, key decode and a 4-digit BCD entry register.
// Optional macro KEYPAD_CLEAR_EN: an accepted '*' clears the BCD register.
module keypad_scanner #(
    parameter int SCAN_W   = 16,
    parameter int DB_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic        key_valid_o,
    output logic [3:0]  key_code_o,
    output logic [15:0] bcd_o
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [3:0] DB_MAX = 4'(DB_TICKS);
`ifdef KEYPAD_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic [SCAN_W-1:0] div_reg;
    logic              tick;
    logic [3:0]        row_meta_reg;
    logic [3:0]        rows_s_reg;
    state_t            state_reg, state_next;
    logic [1:0]        col_idx_reg, col_idx_next;
    logic [1:0]        row_idx_reg, row_idx_next;
    logic [3:0]        db_cnt_reg, db_cnt_next;
    logic              key_valid_reg, key_valid_next;
    logic [3:0]        key_code_reg, key_code_next;
    logic [15:0]       bcd_reg, bcd_next;
    logic [1:0]        low_row;
    logic [3:0]        new_code;
    logic [15:0]       bcd_upd;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0:    key_map = 4'h1;
            4'h1:    key_map = 4'h2;
            4'h2:    key_map = 4'h3;
            4'h3:    key_map = 4'hA;
            4'h4:    key_map = 4'h4;
            4'h5:    key_map = 4'h5;
            4'h6:    key_map = 4'h6;
            4'h7:    key_map = 4'hB;
            4'h8:    key_map = 4'h7;
            4'h9:    key_map = 4'h8;
            4'hA:    key_map = 4'h9;
            4'hB:    key_map = 4'hC;
            4'hC:    key_map = 4'hE;
            4'hD:    key_map = 4'h0;
            4'hE:    key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign tick = &div_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_o[gi] = (col_idx_reg != 2'(gi));
        end
    endgenerate

    assign key_valid_o = key_valid_reg;
    assign key_code_o  = key_code_reg;
    assign bcd_o       = bcd_reg;

    // Lowest-numbered low row wins when several rows are pulled low together.
    always_comb begin
        low_row = 2'd0;
        casez (rows_s_reg)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: low_row = 2'd0;
        endcase
    end

    always_comb begin
        new_code = key_map(row_idx_reg, col_idx_reg);
        bcd_upd  = bcd_reg;
        if (new_code <= 4'd9) begin
            bcd_upd = {bcd_reg[11:0], new_code};
        end
        if (CLEAR_EN && new_code == 4'hE) begin
            bcd_upd = 16'h0000;
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        row_idx_next   = row_idx_reg;
        db_cnt_next    = db_cnt_reg;
        key_valid_next = 1'b0;
        key_code_next  = key_code_reg;
        bcd_next       = bcd_reg;
        case (state_reg)
            SCAN: begin
                if (tick) begin
                    if (rows_s_reg == 4'hF) begin
                        col_idx_next = col_idx_reg + 2'd1;
                    end else begin
                        row_idx_next = low_row;
                        db_cnt_next  = 4'd0;
                        state_next   = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!rows_s_reg[row_idx_reg]) begin
                        // Outputs load on entry so they are valid alongside the pulse.
                        if (db_cnt_reg == DB_MAX) begin
                            state_next     = PRESSED;
                            key_valid_next = 1'b1;
                            key_code_next  = new_code;
                            bcd_next       = bcd_upd;
                        end else begin
                            db_cnt_next = db_cnt_reg + 4'd1;
                        end
                    end else begin
                        state_next   = SCAN;
                        col_idx_next = col_idx_reg + 2'd1;
                    end
                end
            end
            PRESSED: begin
                state_next  = RELEASE_WAIT;
                db_cnt_next = 4'd0;
            end
            RELEASE_WAIT: begin
                if (tick) begin
                    if (rows_s_reg == 4'hF) begin
                        if (db_cnt_reg + 4'd1 == DB_MAX) begin
                            state_next   = SCAN;
                            col_idx_next = col_idx_reg + 2'd1;
                        end else begin
                            db_cnt_next = db_cnt_reg + 4'd1;
                        end
                    end else begin
                        db_cnt_next = 4'd0;
                    end
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg       <= '0;
            row_meta_reg  <= 4'hF;
            rows_s_reg    <= 4'hF;
            state_reg     <= SCAN;
            col_idx_reg   <= 2'd0;
            row_idx_reg   <= 2'd0;
            db_cnt_reg    <= 4'd0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
            bcd_reg       <= 16'h0000;
        end else begin
            div_reg       <= div_reg + 1'b1;
            row_meta_reg  <= row_i;
            rows_s_reg    <= row_meta_reg;
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            row_idx_reg   <= row_idx_next;
            db_cnt_reg    <= db_cnt_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            bcd_reg       <= bcd_next;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner with a physical keypad model driving row_i.
module tb_keypad_scanner;

    localparam int SCAN_W   = 2;
    localparam int DB_TICKS = 3;
`ifdef KEYPAD_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] bcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic        key_valid_o;
    logic [3:0]  key_code_o;
    logic [15:0] bcd_o;

    logic [15:0] held = 16'h0;       // bit r*4+c: key at row r, column c is physically down
    logic [15:0] bcd_model = 16'h0;
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    int          pushed = 0;
    int          key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_W(SCAN_W), .DB_TICKS(DB_TICKS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_valid_o (key_valid_o),
        .key_code_o  (key_code_o),
        .bcd_o       (bcd_o)
    );

    // A held key shorts its row to its column; the row reads low while that column is strobed.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] next_bcd(input logic [15:0] b, input int code);
        if (code < 10) return {b[11:0], 4'(code)};
        if (code == 14 && CLEAR) return 16'h0000;
        return b;
    endfunction

    always @(negedge clk) begin
        if (rst_n && key_valid_o) begin
            exp_t e;
            pulses++;
            $display("pulse: code=%h bcd=%h", key_code_o, bcd_o);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(key_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("key_code", 32'(key_code_o), 32'(e.code));
                check("bcd", 32'(bcd_o), 32'(e.bcd));
            end
        end
    end

    task automatic expect_key(input int k);
        exp_t e;
        bcd_model = next_bcd(bcd_model, key_tab[k]);
        e.code = 4'(key_tab[k]);
        e.bcd = bcd_model;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic press(input int k, input int hold_clk, input bit accepted);
        if (accepted) expect_key(k);
        held[k] = 1'b1;
        repeat (hold_clk) @(negedge clk);
        held[k] = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] want);
        int n = 0;
        while (col_o !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (col_o !== want) check("wait_col_timeout", 32'(col_o), 32'(want));
    endtask

    task automatic check_reset_state();
        check("rst_col", 32'(col_o), 32'h0E);
        check("rst_valid", 32'(key_valid_o), 32'd0);
        check("rst_code", 32'(key_code_o), 32'd0);
        check("rst_bcd", 32'(bcd_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_col;
        int last, changes, p0, k;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // Idle scanning: one column low, rotation order, 4 clk per column.
        prev_col = col_o;
        last = -1;
        changes = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            check("col_onehot", 32'($countones(col_o)), 32'd3);
            if (col_o != prev_col) begin
                check("col_rotate", 32'(col_o), 32'({prev_col[2:0], prev_col[3]}));
                if (last >= 0) check("col_period", 32'(cyc - last), 32'd4);
                last = cyc;
                changes++;
                prev_col = col_o;
            end
        end
        check("col_changes", 32'(changes >= 5), 32'd1);
        check("idle_no_pulse", 32'(pulses), 32'd0);

        // Long hold of '5' gives one pulse only.
        press(5, 200, 1'b1);
        check("five_bcd", 32'(bcd_o), 32'h0005);

        press(0, 60, 1'b1);
        press(1, 60, 1'b1);
        press(2, 60, 1'b1);
        press(4, 60, 1'b1);
        press(10, 60, 1'b1);
        check("seq_bcd", 32'(bcd_o), 32'h2349);
        check("seq_pulses", 32'(pulses), 32'd6);

        // Short glitch on col2, row0: no pulse, scan resumes at col3.
        p0 = pulses;
        wait_col(4'b1011);
        held[2] = 1'b1;
        repeat (8) @(negedge clk);
        held[2] = 1'b0;
        wait_col(4'b1011);
        for (int n = 0; n < 100 && col_o == 4'b1011; n++) @(negedge clk);
        check("glitch_next_col", 32'(col_o), 32'h07);
        repeat (40) @(negedge clk);
        check("glitch_no_pulse", 32'(pulses), 32'(p0));
        check("glitch_bcd", 32'(bcd_o), 32'h2349);

        press(0, 60, 1'b1);
        press(1, 60, 1'b1);
        press(2, 60, 1'b1);
        press(4, 60, 1'b1);
        check("bcd_1234", 32'(bcd_o), 32'h1234);
        press(14, 60, 1'b1);
        check("hash_code", 32'(key_code_o), 32'hF);
        check("hash_bcd", 32'(bcd_o), 32'h1234);
        press(12, 60, 1'b1);
        check("star_code", 32'(key_code_o), 32'hE);
        check("star_bcd", 32'(bcd_o), CLEAR ? 32'h0000 : 32'h1234);

        // Second key during release wait is ignored.
        expect_key(0);
        held[0] = 1'b1;
        repeat (50) @(negedge clk);
        held[1] = 1'b1;
        repeat (50) @(negedge clk);
        held = 16'h0;
        repeat (60) @(negedge clk);

        // Random mix of real presses and glitches.
        for (int i = 0; i < 16; i++) begin
            k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) press(k, int'($urandom_range(1, 8)), 1'b0);
            else press(k, int'($urandom_range(45, 80)), 1'b1);
        end
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during debounce of '7'.
        wait_col(4'b1110);
        held[8] = 1'b1;
        repeat (8) @(negedge clk);
        p0 = pulses;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        held[8] = 1'b0;
        bcd_model = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_abort_no_pulse", 32'(pulses), 32'(p0));
        check("rst_abort_bcd", 32'(bcd_o), 32'h0000);

        // Rows 0 and 2 together on col0: row 0 ('1') wins.
        expect_key(0);
        held[0] = 1'b1;
        held[8] = 1'b1;
        repeat (60) @(negedge clk);
        held = 16'h0;
        repeat (60) @(negedge clk);
        check("multi_row_code", 32'(key_code_o), 32'h1);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
